fpu_mem_responder: RTL



---
 rtl/fpu_mem_pkg.sv | 23 ++
 rtl/fpu_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mem_pkg.sv
// Shared types for the FPU memory responder: FSM state encoding,
// default line size and the beats-per-request derivation.
package fpu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_FETCH,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT
    } state_e;

    localparam int LINE_BYTES_DEF = 64;
    localparam int MEM_BUFFER_DEF = 512;

    function automatic int beats_of(
        input int buf_bytes,
        input int line_bytes
    );
        return buf_bytes / line_bytes;
    endfunction

endpackage

// File: rtl/fpu_mem_responder.sv
// FPU memory responder: moves one buffer (BEATS beats of LINE_BYTES)
// between the FPU fill/result buffers and memory, one beat in flight.
// Ports: request_read/request_write pulses with base addresses;
// drain_rd_* reads the result buffer (1-cycle latency); fill_wr_*
// writes the fill buffer; mem_req_*/mem_rsp_* is the memory side;
// making_request is busy, req_overflow flags dropped requests.
// Optional: FPU_MEM_PROFILE_EN adds perf_busy_cycles/perf_beats.
module fpu_mem_responder
    import fpu_mem_pkg::*;
#(
    parameter int MEM_BUFFER_WIDTH = MEM_BUFFER_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    localparam int BEATS = beats_of(MEM_BUFFER_WIDTH, LINE_BYTES),
    localparam int IW = $clog2(BEATS),
    localparam int DW = LINE_BYTES * 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          request_read,
    input  logic [31:0]   read_address,
    input  logic          request_write,
    input  logic [31:0]   write_address,
    output logic          making_request,
    output logic          fill_wr_en,
    output logic [IW-1:0] fill_wr_idx,
    output logic [DW-1:0] fill_wr_data,
    output logic          drain_rd_en,
    output logic [IW-1:0] drain_rd_idx,
    input  logic [DW-1:0] drain_rd_data,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_we,
    output logic [31:0]   mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_rdata,
    output logic          req_overflow
`ifdef FPU_MEM_PROFILE_EN
    ,
    output logic [31:0]   perf_busy_cycles,
    output logic [31:0]   perf_beats
`endif
);

    localparam logic [31:0] LB32 = 32'(LINE_BYTES);
    localparam logic [31:0] ALIGN = ~(LB32 - 32'd1);
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] beat_q, beat_d;
    logic [31:0]   rd_base_q, rd_base_d;
    logic [31:0]   wr_base_q, wr_base_d;
    logic          rd_pend_q, rd_pend_d;
    logic          loaded_q, loaded_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ovf_q, ovf_d;

    logic          idle;
    logic          last;
    logic          req_any;
    logic [31:0]   beat_off;

    assign idle    = (state_q == IDLE);
    assign last    = (beat_q == LAST);
    assign req_any = request_read | request_write;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rd_base_d = rd_base_q;
        wr_base_d = wr_base_q;
        rd_pend_d = rd_pend_q;
        loaded_d  = loaded_q;
        wdata_d   = wdata_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (request_write) begin
                    wr_base_d = write_address & ALIGN;
                    state_d   = WR_FETCH;
                    if (request_read) begin
                        rd_base_d = read_address & ALIGN;
                        rd_pend_d = 1'b1;
                    end
                end else if (request_read) begin
                    rd_base_d = read_address & ALIGN;
                    state_d   = RD_ISSUE;
                end
            end
            WR_FETCH: begin
                loaded_d = 1'b0;
                state_d  = WR_ISSUE;
            end
            WR_ISSUE: begin
                // First cycle captures the result-buffer read; the
                // request is only offered once the data is held.
                if (!loaded_q) begin
                    wdata_d  = drain_rd_data;
                    loaded_d = 1'b1;
                end else if (mem_req_ready) begin
                    loaded_d = 1'b0;
                    if (last) begin
                        beat_d = '0;
                        if (rd_pend_q) begin
                            rd_pend_d = 1'b0;
                            state_d   = RD_ISSUE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = WR_FETCH;
                    end
                end
            end
            RD_ISSUE: begin
                if (mem_req_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rsp_valid) begin
                    if (last) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!idle && req_any) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            rd_pend_q <= 1'b0;
            loaded_q  <= 1'b0;
            wdata_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rd_base_q <= rd_base_d;
            wr_base_q <= wr_base_d;
            rd_pend_q <= rd_pend_d;
            loaded_q  <= loaded_d;
            wdata_q   <= wdata_d;
            ovf_q     <= ovf_d;
        end
    end

    assign making_request = req_any | !idle;
    assign drain_rd_en    = (state_q == WR_FETCH);
    assign drain_rd_idx   = drain_rd_en ? beat_q : '0;
    assign mem_req_we     = (state_q == WR_ISSUE) & loaded_q;
    assign mem_req_valid  = mem_req_we | (state_q == RD_ISSUE);
    assign beat_off       = 32'(beat_q) * LB32;
    assign mem_req_addr   = !mem_req_valid ? '0 :
                            (mem_req_we ? wr_base_q : rd_base_q)
                            + beat_off;
    assign mem_req_wdata  = wdata_q;
    assign fill_wr_en     = (state_q == RD_WAIT) & mem_rsp_valid;
    assign fill_wr_idx    = fill_wr_en ? beat_q : '0;
    assign fill_wr_data   = fill_wr_en ? mem_rsp_rdata : '0;
    assign req_overflow   = ovf_q;

`ifdef FPU_MEM_PROFILE_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] nbeat_q, nbeat_d;
    logic        beat_done;

    assign beat_done = (mem_req_we & mem_req_ready) | fill_wr_en;

    always_comb begin
        busy_d  = busy_q;
        nbeat_d = nbeat_q;
        if (!idle && busy_q != '1) busy_d = busy_q + 32'd1;
        if (beat_done && nbeat_q != '1) nbeat_d = nbeat_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            nbeat_q <= '0;
        end else begin
            busy_q  <= busy_d;
            nbeat_q <= nbeat_d;
        end
    end

    assign perf_busy_cycles = busy_q;
    assign perf_beats       = nbeat_q;
`endif

endmodule
